csr: RTL and testbench
======================

// Module: csr
// PURPOSE
// - Machine-mode CSR file for the RV32IM 5-stage core; sits beside the regfile and is accessed from ID.
// - ID reads one CSR per cycle combinationally for Zicsr instructions.
// - ID writes one CSR per cycle through the generic port.
// - ID also drives dedicated trap-entry writes: mepc, mcause, mtval and the MIE stacking request.
// PARAMETERS
// - XLEN      32            data width of every CSR port
// - HART_ID   0             value returned by mhartid
// - MISA_VAL  32'h4000_1100 read-only misa (MXL=1, I, M)
// PORTS
// - clk                  in   1     single clock; all state updates on rising edge
// - rst                  in   1     asynchronous, active-low reset
// - we_i                 in   1     generic CSR write enable
// - waddr_i              in   12    generic write address
// - wdata_i              in   XLEN  generic write data (final value; ID already resolved RW/RS/RC)
// - we_mtval_i           in   1     trap write of mtval
// - wdata_mtval_i        in   XLEN  trap mtval value
// - we_mepc_i            in   1     trap write of mepc
// - wdata_mepc_i         in   XLEN  trap mepc value
// - we_mcause_i          in   1     trap write of mcause
// - wdata_mcause_i       in   XLEN  trap mcause value
// - exception_mie_req_i  in   1     trap entry: stack and clear mstatus.MIE
// - raddr_i              in   12    read address
// - rdata_o              out  XLEN  read data, combinational
// BEHAVIOUR
// - Implemented CSRs:
//   - mstatus 0x300, misa 0x301, mie 0x304, mtvec 0x305, mscratch 0x340
//   - mepc 0x341, mcause 0x342, mtval 0x343, mip 0x344
//   - mcycle 0xB00, mcycleh 0xB80
//   - mvendorid 0xF11, marchid 0xF12, mimpid 0xF13 read 0; mhartid 0xF14 reads HART_ID
// - Reset (rst low, async): every register is 0, mcycle is 0, mstatus.MPP is 2'b11.
//   rdata_o then follows raddr_i: 0 for most CSRs, MISA_VAL / HART_ID for the constants, mstatus reads 32'h0000_1800.
// - Read: rdata_o = current value of CSR[raddr_i], zero latency. Unimplemented addresses read 0.
// - Read bypass: if we_i=1 and waddr_i==raddr_i for a writable CSR, rdata_o returns the masked wdata_i (same-cycle forwarding).
// - Generic write takes effect at the next edge. Writes to read-only or unimplemented addresses are ignored.
// - Write masks:
//   - mstatus: only MIE[3] and MPIE[7] are writable; MPP[12:11] is hardwired to 2'b11; all other bits read 0.
//   - mepc: bits [1:0] are forced to 0.
//   - mtvec: bit 1 is forced to 0 (MODE is Direct or Vectored only).
//   - mie / mip: bits 3, 7, 11 are writable; mip is writable by software only (no external interrupt inputs).
//   - mscratch, mcause, mtval: full XLEN.
// - Trap ports: each we_*_i loads its register at the next edge with the same mask as above.
//   If it coincides with a generic write to the same CSR, the trap port wins.
// - exception_mie_req_i=1: at the next edge MPIE <= MIE and MIE <= 0.
//   This overrides a simultaneous generic write to mstatus.
// - mcycle/mcycleh: 64-bit counter, +1 every cycle, wraps from all-ones to 0.
//   A generic write to either half replaces that half for that cycle; no increment is applied that cycle.
// - No internal state machine; all outputs are combinational from registers plus the bypass path.
// STRUCTURE
// - Shared package csr_pkg: 12-bit CSR address constants, mstatus bit positions, MISA_VAL.
// - No sub-module; a single flat always_ff register block plus an always_comb read mux.
// TESTING
// - Reset: rst=0 then 1, raddr=0x300 -> rdata 32'h0000_1800; raddr=0x301 -> 32'h4000_1100; raddr=0x7C0 -> 0.
// - Write then read: we=1, waddr=0x340, wdata=32'hDEAD_BEEF -> same-cycle raddr=0x340 returns DEAD_BEEF (bypass) and the value persists next cycle.
// - Masking:
//   - write 0x300 with 32'hFFFF_FFFF -> reads 32'h0000_1888.
//   - write 0x341 with 32'h1003 -> reads 32'h1000.
// - Trap entry: MIE=1, then exception_mie_req=1, we_mepc=1 with 32'h80, we_mcause=1 with 11, we_mtval=1 with 0, plus a generic write of 0x341 with 32'h40 in the same cycle
//   -> mstatus reads 32'h0000_1880, mepc=32'h80, mcause=11.
// - Counter: after 10 cycles out of reset mcycle reads 10.
//   Write 0xB00 with 32'hFFFF_FFFF, then after 1 cycle -> mcycle=0 and mcycleh=1.
// - Async reset mid-operation: assert rst between edges -> all registers clear immediately, without waiting for clk.

Source files
------------

// File: rtl/csr_pkg.sv
//------------------------------------------------------------------------------
// csr_pkg : CSR address map, mstatus bit positions and write masks.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package csr_pkg;

    localparam int unsigned CSR_XLEN = 32;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;
    localparam logic [11:0] CSR_MIMPID    = 12'hF13;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    localparam int unsigned MSTATUS_MIE_BIT  = 3;
    localparam int unsigned MSTATUS_MPIE_BIT = 7;
    localparam int unsigned MSTATUS_MPP_LO   = 11;
    localparam int unsigned MSTATUS_MPP_HI   = 12;

    localparam logic [31:0] CSR_MISA_VAL = 32'h4000_1100;

    // mie/mip: software, timer and external interrupt bits only
    localparam logic [31:0] MIX_MASK   = 32'h0000_0888;
    localparam logic [31:0] MEPC_MASK  = 32'hFFFF_FFFC;
    localparam logic [31:0] MTVEC_MASK = 32'hFFFF_FFFD;

    function automatic logic csr_writable(input logic [11:0] addr);
        case (addr)
            CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC,
            CSR_MCAUSE, CSR_MTVAL, CSR_MIP, CSR_MCYCLE, CSR_MCYCLEH:
                csr_writable = 1'b1;
            default:
                csr_writable = 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/csr.sv
//------------------------------------------------------------------------------
// csr : machine-mode CSR file with combinational read, same-cycle write bypass,
//       dedicated trap-entry ports and a free-running 64-bit mcycle counter.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module csr
    import csr_pkg::*;
#(
    parameter int unsigned          XLEN     = CSR_XLEN,
    parameter int unsigned          HART_ID  = 0,
    parameter logic [XLEN-1:0]      MISA_VAL = XLEN'(CSR_MISA_VAL)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we_i,
    input  logic [11:0]         waddr_i,
    input  logic [XLEN-1:0]     wdata_i,
    input  logic                we_mtval_i,
    input  logic [XLEN-1:0]     wdata_mtval_i,
    input  logic                we_mepc_i,
    input  logic [XLEN-1:0]     wdata_mepc_i,
    input  logic                we_mcause_i,
    input  logic [XLEN-1:0]     wdata_mcause_i,
    input  logic                exception_mie_req_i,
    input  logic [11:0]         raddr_i,
    output logic [XLEN-1:0]     rdata_o
);

    localparam logic [XLEN-1:0] MIX_M   = XLEN'(MIX_MASK);
    localparam logic [XLEN-1:0] MEPC_M  = XLEN'(MEPC_MASK);
    localparam logic [XLEN-1:0] MTVEC_M = XLEN'(MTVEC_MASK);

    logic                   mstatus_mie_q,  mstatus_mie_d;
    logic                   mstatus_mpie_q, mstatus_mpie_d;
    logic [XLEN-1:0]        mie_q,      mie_d;
    logic [XLEN-1:0]        mtvec_q,    mtvec_d;
    logic [XLEN-1:0]        mscratch_q, mscratch_d;
    logic [XLEN-1:0]        mepc_q,     mepc_d;
    logic [XLEN-1:0]        mcause_q,   mcause_d;
    logic [XLEN-1:0]        mtval_q,    mtval_d;
    logic [XLEN-1:0]        mip_q,      mip_d;
    logic [2*XLEN-1:0]      mcycle_q,   mcycle_d;

    function automatic logic [XLEN-1:0] mstatus_val(input logic mie, input logic mpie);
        logic [XLEN-1:0] v;
        v = '0;
        v[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        v[MSTATUS_MPIE_BIT]              = mpie;
        v[MSTATUS_MIE_BIT]               = mie;
        return v;
    endfunction

    // Value a generic write would leave in the addressed CSR
    function automatic logic [XLEN-1:0] wmask(input logic [11:0] addr, input logic [XLEN-1:0] d);
        case (addr)
            CSR_MSTATUS:      wmask = mstatus_val(d[MSTATUS_MIE_BIT], d[MSTATUS_MPIE_BIT]);
            CSR_MEPC:         wmask = d & MEPC_M;
            CSR_MTVEC:        wmask = d & MTVEC_M;
            CSR_MIE, CSR_MIP: wmask = d & MIX_M;
            default:          wmask = d;
        endcase
    endfunction

    function automatic logic gen_hit(input logic we, input logic [11:0] wa, input logic [11:0] csr);
        return we && (wa == csr);
    endfunction

    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        if (gen_hit(we_i, waddr_i, CSR_MSTATUS)) begin
            mstatus_mie_d  = wdata_i[MSTATUS_MIE_BIT];
            mstatus_mpie_d = wdata_i[MSTATUS_MPIE_BIT];
        end
        if (exception_mie_req_i) begin
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end

        mie_d      = gen_hit(we_i, waddr_i, CSR_MIE)      ? (wdata_i & MIX_M)   : mie_q;
        mip_d      = gen_hit(we_i, waddr_i, CSR_MIP)      ? (wdata_i & MIX_M)   : mip_q;
        mtvec_d    = gen_hit(we_i, waddr_i, CSR_MTVEC)    ? (wdata_i & MTVEC_M) : mtvec_q;
        mscratch_d = gen_hit(we_i, waddr_i, CSR_MSCRATCH) ? wdata_i             : mscratch_q;

        // Trap ports take priority over the generic port
        mepc_d = mepc_q;
        if (gen_hit(we_i, waddr_i, CSR_MEPC)) mepc_d = wdata_i & MEPC_M;
        if (we_mepc_i)                        mepc_d = wdata_mepc_i & MEPC_M;

        mcause_d = mcause_q;
        if (gen_hit(we_i, waddr_i, CSR_MCAUSE)) mcause_d = wdata_i;
        if (we_mcause_i)                        mcause_d = wdata_mcause_i;

        mtval_d = mtval_q;
        if (gen_hit(we_i, waddr_i, CSR_MTVAL)) mtval_d = wdata_i;
        if (we_mtval_i)                        mtval_d = wdata_mtval_i;

        if (gen_hit(we_i, waddr_i, CSR_MCYCLE)) begin
            mcycle_d = {mcycle_q[2*XLEN-1:XLEN], wdata_i};
        end else if (gen_hit(we_i, waddr_i, CSR_MCYCLEH)) begin
            mcycle_d = {wdata_i, mcycle_q[XLEN-1:0]};
        end else begin
            mcycle_d = mcycle_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= '0;
            mtvec_q        <= '0;
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mtval_q        <= '0;
            mip_q          <= '0;
            mcycle_q       <= '0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_q          <= mie_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mtval_q        <= mtval_d;
            mip_q          <= mip_d;
            mcycle_q       <= mcycle_d;
        end
    end

    always_comb begin
        rdata_o = '0;
        case (raddr_i)
            CSR_MSTATUS:  rdata_o = mstatus_val(mstatus_mie_q, mstatus_mpie_q);
            CSR_MISA:     rdata_o = MISA_VAL;
            CSR_MIE:      rdata_o = mie_q;
            CSR_MTVEC:    rdata_o = mtvec_q;
            CSR_MSCRATCH: rdata_o = mscratch_q;
            CSR_MEPC:     rdata_o = mepc_q;
            CSR_MCAUSE:   rdata_o = mcause_q;
            CSR_MTVAL:    rdata_o = mtval_q;
            CSR_MIP:      rdata_o = mip_q;
            CSR_MCYCLE:   rdata_o = mcycle_q[XLEN-1:0];
            CSR_MCYCLEH:  rdata_o = mcycle_q[2*XLEN-1:XLEN];
            CSR_MHARTID:  rdata_o = XLEN'(HART_ID);
            default:      rdata_o = '0;
        endcase
        if (we_i && (waddr_i == raddr_i) && csr_writable(raddr_i)) begin
            rdata_o = wmask(raddr_i, wdata_i);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_csr.sv
//------------------------------------------------------------------------------
// tb_csr : vector table plus hand-written trap, counter and async-reset sequences.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_csr;

    logic        clk = 1'b0;
    logic        rst;
    logic        we_i;
    logic [11:0] waddr_i;
    logic [31:0] wdata_i;
    logic        we_mtval_i;
    logic [31:0] wdata_mtval_i;
    logic        we_mepc_i;
    logic [31:0] wdata_mepc_i;
    logic        we_mcause_i;
    logic [31:0] wdata_mcause_i;
    logic        exception_mie_req_i;
    logic [11:0] raddr_i;
    logic [31:0] rdata_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        we;
        logic [11:0] waddr;
        logic [31:0] wdata;
        logic [11:0] raddr;
        logic [31:0] exp_now;
        logic [11:0] raddr2;
        logic [31:0] exp_next;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[14];

    csr #(.HART_ID(3)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .we_i                (we_i),
        .waddr_i             (waddr_i),
        .wdata_i             (wdata_i),
        .we_mtval_i          (we_mtval_i),
        .wdata_mtval_i       (wdata_mtval_i),
        .we_mepc_i           (we_mepc_i),
        .wdata_mepc_i        (wdata_mepc_i),
        .we_mcause_i         (we_mcause_i),
        .wdata_mcause_i      (wdata_mcause_i),
        .exception_mie_req_i (exception_mie_req_i),
        .raddr_i             (raddr_i),
        .rdata_o             (rdata_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive a read address, queue its expectation, then sample 1 time unit later
    task automatic rd(input string name, input logic [11:0] a, input logic [31:0] e);
        exp_t x;
        exp_t got;
        raddr_i = a;
        x.name  = name;
        x.val   = e;
        exp_q.push_back(x);
        #1;
        got = exp_q.pop_front();
        total++;
        if (rdata_o !== got.val) begin
            bad++;
            $display("FAIL %s: addr=%h got=%h expected=%h", got.name, a, rdata_o, got.val);
        end
    endtask

    task automatic idle_inputs();
        we_i = 1'b0; waddr_i = '0; wdata_i = '0;
        we_mtval_i = 1'b0; wdata_mtval_i = '0;
        we_mepc_i = 1'b0; wdata_mepc_i = '0;
        we_mcause_i = 1'b0; wdata_mcause_i = '0;
        exception_mie_req_i = 1'b0;
    endtask

    task automatic gen_write(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        idle_inputs();
        we_i = 1'b1; waddr_i = a; wdata_i = d;
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        vecs[0]  = '{1'b0, 12'h000, 32'h0,         12'h300, 32'h0000_1800, 12'h301, 32'h4000_1100};
        vecs[1]  = '{1'b0, 12'h000, 32'h0,         12'h7C0, 32'h0,         12'hF14, 32'h3};
        vecs[2]  = '{1'b1, 12'h340, 32'hDEAD_BEEF, 12'h340, 32'hDEAD_BEEF, 12'h340, 32'hDEAD_BEEF};
        vecs[3]  = '{1'b1, 12'h300, 32'hFFFF_FFFF, 12'h300, 32'h0000_1888, 12'h300, 32'h0000_1888};
        vecs[4]  = '{1'b1, 12'h341, 32'h0000_1003, 12'h341, 32'h0000_1000, 12'h341, 32'h0000_1000};
        vecs[5]  = '{1'b1, 12'h305, 32'hFFFF_FFFF, 12'h305, 32'hFFFF_FFFD, 12'h305, 32'hFFFF_FFFD};
        vecs[6]  = '{1'b1, 12'h304, 32'hFFFF_FFFF, 12'h304, 32'h0000_0888, 12'h304, 32'h0000_0888};
        vecs[7]  = '{1'b1, 12'h344, 32'h0000_0F0F, 12'h344, 32'h0000_0808, 12'h344, 32'h0000_0808};
        vecs[8]  = '{1'b1, 12'h301, 32'h0,         12'h301, 32'h4000_1100, 12'h301, 32'h4000_1100};
        vecs[9]  = '{1'b1, 12'h7C0, 32'h0000_1234, 12'h7C0, 32'h0,         12'h7C0, 32'h0};
        vecs[10] = '{1'b1, 12'h342, 32'h8000_000B, 12'h342, 32'h8000_000B, 12'h343, 32'h0};
        vecs[11] = '{1'b1, 12'h343, 32'hAAAA_5555, 12'h340, 32'hDEAD_BEEF, 12'h343, 32'hAAAA_5555};
        vecs[12] = '{1'b1, 12'hF14, 32'h0000_00FF, 12'hF14, 32'h3,         12'hF11, 32'h0};
        vecs[13] = '{1'b1, 12'h300, 32'h0,         12'h300, 32'h0000_1800, 12'h300, 32'h0000_1800};

        idle_inputs();
        raddr_i = 12'h300;
        rst     = 1'b0;
        #1;
        rd("reset_mstatus", 12'h300, 32'h0000_1800);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Ten rising edges after release
        repeat (10) @(negedge clk);
        rd("mcycle_10",  12'hB00, 32'd10);
        rd("mcycleh_0",  12'hB80, 32'd0);

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            idle_inputs();
            we_i = vecs[i].we; waddr_i = vecs[i].waddr; wdata_i = vecs[i].wdata;
            rd($sformatf("vec%0d_now", i), vecs[i].raddr, vecs[i].exp_now);
            @(negedge clk);
            idle_inputs();
            rd($sformatf("vec%0d_next", i), vecs[i].raddr2, vecs[i].exp_next);
        end

        // Trap entry with a colliding generic mepc write
        gen_write(12'h300, 32'h0000_0008);
        rd("mie_set", 12'h300, 32'h0000_1808);
        idle_inputs();
        exception_mie_req_i = 1'b1;
        we_mepc_i   = 1'b1; wdata_mepc_i   = 32'h80;
        we_mcause_i = 1'b1; wdata_mcause_i = 32'd11;
        we_mtval_i  = 1'b1; wdata_mtval_i  = 32'h0;
        we_i = 1'b1; waddr_i = 12'h341; wdata_i = 32'h40;
        @(negedge clk);
        idle_inputs();
        rd("trap_mstatus", 12'h300, 32'h0000_1880);
        rd("trap_mepc",    12'h341, 32'h0000_0080);
        rd("trap_mcause",  12'h342, 32'd11);
        rd("trap_mtval",   12'h343, 32'h0);

        // Stacking request overrides a generic mstatus write
        idle_inputs();
        exception_mie_req_i = 1'b1;
        we_i = 1'b1; waddr_i = 12'h300; wdata_i = 32'h0000_0008;
        @(negedge clk);
        idle_inputs();
        rd("trap_over_gen", 12'h300, 32'h0000_1800);

        // Counter wrap from low half into high half
        gen_write(12'hB80, 32'h0);
        @(negedge clk);
        we_i = 1'b1; waddr_i = 12'hB00; wdata_i = 32'hFFFF_FFFF;
        rd("mcycle_bypass", 12'hB00, 32'hFFFF_FFFF);
        @(negedge clk);
        idle_inputs();
        rd("mcycle_written", 12'hB00, 32'hFFFF_FFFF);
        rd("mcycleh_before", 12'hB80, 32'h0);
        @(negedge clk);
        rd("mcycle_wrap",  12'hB00, 32'h0);
        rd("mcycleh_wrap", 12'hB80, 32'h1);

        // Asynchronous reset between edges
        gen_write(12'h340, 32'h1234_5678);
        gen_write(12'h300, 32'h0000_0088);
        rd("pre_rst_mscratch", 12'h340, 32'h1234_5678);
        #1;
        rst = 1'b0;
        rd("arst_mscratch", 12'h340, 32'h0);
        rd("arst_mstatus",  12'h300, 32'h0000_1800);
        rd("arst_mcycle",   12'hB00, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rd("post_rst_mcycle", 12'hB00, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
